// File: rtl/lapido_pkg.sv
// lapido_pkg: shared flag-register definitions for the lapido core.
package lapido_pkg;
  localparam int FLAG_W     = 6;
  localparam int PIPE_DEPTH = 3;
  localparam int FL_Z = 0;
  localparam int FL_N = 1;
  localparam int FL_C = 2;
  localparam int FL_V = 3;
  localparam int FL_P = 4;
  localparam int FL_H = 5;
  typedef logic [FLAG_W-1:0] flags_t;
endpackage

// File: rtl/flag_shadow_pipe.sv
// flag_shadow_pipe: pending/flag-value shift register from EX (slot 0) to WB, with hold and slot-1 kill.
module flag_shadow_pipe #(
  parameter int W     = lapido_pkg::FLAG_W,
  parameter int DEPTH = lapido_pkg::PIPE_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_hold,
  input  logic                      i_kill,
  input  logic                      i_issue,
  input  logic [W-1:0]              i_alu_flags,
  output logic [DEPTH-1:0]          o_pending,
  output logic [DEPTH-1:1][W-1:0]   o_fv
);
  logic [DEPTH-1:0]        r_pend;
  logic [DEPTH-1:1][W-1:0] r_fv;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_fv   <= '0;
    end else if (!i_hold) begin
      r_pend[0] <= i_issue;
      r_pend[1] <= r_pend[0] & ~i_kill;
      r_fv[1]   <= i_alu_flags;
      for (int i = 2; i < DEPTH; i++) begin
        r_pend[i] <= r_pend[i-1];
        r_fv[i]   <= r_fv[i-1];
      end
    end
  end
  assign o_pending = r_pend;
  assign o_fv      = r_fv;
endmodule

// File: rtl/flags_hazard_ctrl.sv
// flags_hazard_ctrl: schedules flag-register commits at WB and stalls flag readers in ID.
// Define FLAGS_FWD_EN to forward in-flight flags (slot 1 and older) to ID instead of stalling.
module flags_hazard_ctrl #(
  parameter int FLAG_W     = lapido_pkg::FLAG_W,
  parameter int PIPE_DEPTH = lapido_pkg::PIPE_DEPTH,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_hold,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic                  id_sets_flags,
  input  logic                  id_reads_flags,
  input  logic [FLAG_W-1:0]     alu_flags,
  input  logic [FLAG_W-1:0]     flags_q,
  output logic                  issue_stall,
  output logic                  fl_write_enable,
  output logic [FLAG_W-1:0]     fl_data,
  output logic [FLAG_W-1:0]     eff_flags,
  output logic [PIPE_DEPTH-1:0] pending,
  output logic [CNT_W-1:0]      stall_count
);
  logic [PIPE_DEPTH-1:0]             w_pending;
  logic [PIPE_DEPTH-1:1][FLAG_W-1:0] w_fv;
  logic                              w_issue;
  logic [CNT_W-1:0]                  r_stall_count;
  assign w_issue = id_valid & id_sets_flags & ~issue_stall & ~flush;
  flag_shadow_pipe #(.W(FLAG_W), .DEPTH(PIPE_DEPTH)) u_pipe (
    .clk         (clk),
    .rst         (rst),
    .i_hold      (pipe_hold),
    .i_kill      (flush),
    .i_issue     (w_issue),
    .i_alu_flags (alu_flags),
    .o_pending   (w_pending),
    .o_fv        (w_fv)
  );
`ifdef FLAGS_FWD_EN
  // Scan oldest to youngest so the youngest pending slot wins.
  always_comb begin
    issue_stall = id_valid & id_reads_flags & w_pending[0];
    eff_flags   = flags_q;
    for (int i = PIPE_DEPTH - 1; i >= 1; i--)
      if (w_pending[i]) eff_flags = w_fv[i];
  end
`else
  logic w_unused_fv;
  assign w_unused_fv = ^w_fv;
  // The WB slot still counts: flags_q only picks up its value at the edge.
  always_comb begin
    issue_stall = id_valid & id_reads_flags & (|w_pending);
    eff_flags   = flags_q;
  end
`endif
  // Flush clears the flag register itself, so a WB commit is dropped.
  assign fl_write_enable = w_pending[PIPE_DEPTH-1] & ~pipe_hold & ~flush & ~rst;
  assign fl_data         = w_fv[PIPE_DEPTH-1];
  assign pending         = w_pending;
  assign stall_count     = r_stall_count;
  always_ff @(posedge clk) begin
    if (rst) r_stall_count <= '0;
    else if (issue_stall && !pipe_hold && !(&r_stall_count)) r_stall_count <= r_stall_count + 1'b1;
  end
endmodule

// File: tb/tb_flags_hazard_ctrl.sv
// tb_flags_hazard_ctrl: directed self-checking bench for flags_hazard_ctrl (base or FLAGS_FWD_EN build).
module tb_flags_hazard_ctrl;
  import lapido_pkg::*;
`ifdef FLAGS_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, pipe_hold = 1'b0, flush = 1'b0;
  logic id_valid = 1'b0, id_sets_flags = 1'b0, id_reads_flags = 1'b0;
  flags_t alu_flags = '0, flags_q = 6'h2A;
  logic issue_stall, fl_write_enable;
  flags_t fl_data, eff_flags;
  logic [2:0] pending;
  logic [15:0] stall_count;
  logic s_stall, s_we;
  flags_t s_data, s_eff;
  logic [2:0] s_pend;
  logic [1:0] s_cnt;
  int vec = 0, errs = 0;

  flags_hazard_ctrl dut (
    .clk(clk), .rst(rst), .pipe_hold(pipe_hold), .flush(flush),
    .id_valid(id_valid), .id_sets_flags(id_sets_flags), .id_reads_flags(id_reads_flags),
    .alu_flags(alu_flags), .flags_q(flags_q),
    .issue_stall(issue_stall), .fl_write_enable(fl_write_enable), .fl_data(fl_data),
    .eff_flags(eff_flags), .pending(pending), .stall_count(stall_count)
  );

  flags_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .pipe_hold(pipe_hold), .flush(flush),
    .id_valid(id_valid), .id_sets_flags(id_sets_flags), .id_reads_flags(id_reads_flags),
    .alu_flags(alu_flags), .flags_q(flags_q),
    .issue_stall(s_stall), .fl_write_enable(s_we), .fl_data(s_data),
    .eff_flags(s_eff), .pending(s_pend), .stall_count(s_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id(input logic v, input logic s, input logic r);
    id_valid = v;
    id_sets_flags = s;
    id_reads_flags = r;
  endtask

  initial begin
    tick(); tick();
    #1;
    chk("rst_active_we", fl_write_enable, 0);
    rst = 1'b0; #1;
    chk("rst_pend", pending, 0);
    chk("rst_stall", issue_stall, 0);
    chk("rst_we", fl_write_enable, 0);
    chk("rst_data", fl_data, 0);
    chk("rst_eff", eff_flags, 6'h2A);
    chk("rst_cnt", stall_count, 0);
    chk("rst_s_pend", s_pend, 0);
    chk("rst_s_stall", s_stall, 0);
    chk("rst_s_we", s_we, 0);
    chk("rst_s_data", s_data, 0);
    chk("rst_s_eff", s_eff, 6'h2A);
    chk("rst_s_cnt", s_cnt, 0);
    tick();
    // writer then reader
    id(1, 1, 0); #1;
    chk("w1_stall", issue_stall, 0);
    tick();
    id(1, 0, 1); alu_flags = 6'b000101; #1;
    chk("r1_pend", pending, 3'b001);
    chk("r1_stall0", issue_stall, 1);
    tick();
    alu_flags = '0; #1;
    chk("r1_stall1", issue_stall, FWD ? 0 : 1);
    chk("r1_eff", eff_flags, FWD ? 6'h05 : 6'h2A);
    tick();
    #1;
    chk("r1_we", fl_write_enable, 1);
    chk("r1_data", fl_data, 6'h05);
    chk("r1_stall2", issue_stall, FWD ? 0 : 1);
    tick();
    #1;
    chk("r1_pend_clr", pending, 0);
    chk("r1_stall3", issue_stall, 0);
    chk("r1_we_off", fl_write_enable, 0);
    chk("r1_cnt", stall_count, FWD ? 1 : 3);
    tick();
    // back-to-back writers, reader behind
    id(1, 1, 0); tick();
    id(1, 1, 0); alu_flags = 6'h01; #1;
    chk("b2b_pend1", pending, 3'b001);
    chk("b2b_stall_w", issue_stall, 0);
    tick();
    id(1, 0, 1); alu_flags = 6'h02; #1;
    chk("b2b_pend2", pending, 3'b011);
    chk("b2b_stall0", issue_stall, 1);
    tick();
    alu_flags = '0; #1;
    chk("b2b_we1", fl_write_enable, 1);
    chk("b2b_data1", fl_data, 6'h01);
    chk("b2b_stall1", issue_stall, FWD ? 0 : 1);
    chk("b2b_eff1", eff_flags, FWD ? 6'h02 : 6'h2A);
    tick();
    #1;
    chk("b2b_we2", fl_write_enable, 1);
    chk("b2b_data2", fl_data, 6'h02);
    chk("b2b_eff2", eff_flags, FWD ? 6'h02 : 6'h2A);
    tick();
    id(0, 0, 0); #1;
    chk("b2b_pend_clr", pending, 0);
    chk("b2b_cnt", stall_count, FWD ? 2 : 6);
    tick();
    // flush kills slot 0 and the ID issue; slot 1 still commits
    id(1, 1, 0); tick();
    id(1, 1, 0); alu_flags = 6'h03; tick();
    alu_flags = 6'h07; flush = 1'b1; #1;
    chk("fl_pend", pending, 3'b011);
    chk("fl_we", fl_write_enable, 0);
    tick();
    flush = 1'b0; id(0, 0, 0); #1;
    chk("fl_pend_after", pending, 3'b100);
    chk("fl_old_we", fl_write_enable, 1);
    chk("fl_old_data", fl_data, 6'h03);
    tick();
    #1;
    chk("fl_pend_clr", pending, 0);
    chk("fl_no_we", fl_write_enable, 0);
    tick();
    // flush while a writer sits in WB drops its commit
    id(1, 1, 0); tick();
    id(0, 0, 0); alu_flags = 6'h15; tick();
    tick();
    flush = 1'b1; #1;
    chk("flwb_pend", pending, 3'b100);
    chk("flwb_we", fl_write_enable, 0);
    tick();
    flush = 1'b0; #1;
    chk("flwb_pend_clr", pending, 0);
    chk("flwb_no_we", fl_write_enable, 0);
    tick();
    // 4-cycle hold with a writer in WB
    id(1, 1, 0); tick();
    id(0, 0, 0); alu_flags = 6'h3C; tick();
    tick();
    pipe_hold = 1'b1; id(1, 0, 1); #1;
    chk("hold_we0", fl_write_enable, 0);
    chk("hold_pend0", pending, 3'b100);
    chk("hold_stall", issue_stall, FWD ? 0 : 1);
    tick();
    for (int i = 1; i <= 3; i++) begin
      flush = (i == 2);
      #1;
      chk("hold_pend", pending, 3'b100);
      chk("hold_we", fl_write_enable, 0);
      tick();
    end
    pipe_hold = 1'b0; flush = 1'b0; id(0, 0, 0); #1;
    chk("hold_rel_pend", pending, 3'b100);
    chk("hold_rel_we", fl_write_enable, 1);
    chk("hold_rel_data", fl_data, 6'h3C);
    chk("hold_cnt", stall_count, FWD ? 2 : 6);
    tick();
    #1;
    chk("hold_pend_clr", pending, 0);
    chk("hold_single_pulse", fl_write_enable, 0);
    // reset with three writers in flight
    id(1, 1, 0); tick(); tick(); tick();
    #1;
    chk("rm_pend_full", pending, 3'b111);
    rst = 1'b1; id(0, 0, 0); #1;
    chk("rm_we_in_rst", fl_write_enable, 0);
    tick();
    rst = 1'b0; #1;
    chk("rm_pend", pending, 0);
    chk("rm_cnt", stall_count, 0);
    chk("rm_s_cnt", s_cnt, 0);
    chk("rm_we", fl_write_enable, 0);
    tick();
    // five stall cycles: 16-bit counter counts, 2-bit counter saturates
    for (int i = 0; i < 5; i++) begin
      id(1, 1, 0); tick();
      id(1, 0, 1); #1;
      chk("sat_stall", issue_stall, 1);
      tick();
    end
    id(0, 0, 0); #1;
    chk("sat_cnt", stall_count, 5);
    chk("sat_s_cnt", s_cnt, 2'b11);
    tick(); tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/flags_hazard_ctrl.md
Name: flags_hazard_ctrl

Overview:
- Scheduler for the 6-bit condition-flag register of the lapido core.
- Tracks in-flight flag-setting instructions from EX to WB and carries their ALU flags down a small shadow pipeline.
- Generates the flag register's write enable and data at WB.
- Stalls flag-reading instructions (conditional branches) in ID until their flags are resolvable.

Parameters:
- FLAG_W, 6, width of the flag vector.
- PIPE_DEPTH, 3, slots from EX (slot 0) to WB (slot PIPE_DEPTH-1); legal range 2..8.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- pipe_hold  in  1  global pipeline freeze (memory wait).
- flush  in  1  branch taken, resolved in slot 1; kills slot 0 and the current ID issue.
- id_valid  in  1  valid instruction in ID.
- id_sets_flags  in  1  ID instruction writes flags.
- id_reads_flags  in  1  ID instruction consumes flags.
- alu_flags  in  FLAG_W  ALU flag result for the slot-0 instruction.
- flags_q  in  FLAG_W  current flag register contents.
- issue_stall  out  1  hold ID this cycle.
- fl_write_enable  out  1  flag register write strobe.
- fl_data  out  FLAG_W  value to write.
- eff_flags  out  FLAG_W  flags presented to the ID consumer.
- pending  out  PIPE_DEPTH  per-slot "flag writer in flight" bits.
- stall_count  out  CNT_W  saturating count of cycles with issue_stall=1.

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values:
  - pending = 0; all slot flag registers = 0; stall_count = 0.
  - Consequently issue_stall = 0, fl_write_enable = 0, fl_data = 0, eff_flags = flags_q.
- Slot state: pending[i] plus flag value fv[i] for i ≥ 1. Slot 0's value is alu_flags (combinational, valid only while pending[0] is set).
- Advance when pipe_hold = 0:
  - pending[i+1] <= pending[i]; fv[1] <= alu_flags; fv[i+1] <= fv[i].
  - pending[0] <= id_valid & id_sets_flags & ~issue_stall & ~flush.
- Flush: when flush = 1, slot 0 is killed, so pending[1] <= 0. Older slots advance normally.
- Hold: when pipe_hold = 1, all slots, fv and stall_count hold. pipe_hold has priority over flush; flush is re-sampled when hold drops.
- Commit (combinational):
  - fl_write_enable = pending[PIPE_DEPTH-1] & ~pipe_hold & ~flush.
  - fl_data = fv[PIPE_DEPTH-1].
  - Commit is suppressed during flush because the flag register clears on branch_taken.
- Hazard (base build):
  - issue_stall = id_valid & id_reads_flags & (|pending).
  - The committing slot counts as a hazard, because flags_q updates only at that edge.
  - eff_flags = flags_q.
- Same-instruction case: an instruction that both reads and sets flags follows the read rule; it enters slot 0 only when not stalled.
- stall_count: increments when issue_stall = 1 and pipe_hold = 0; saturates at all-ones and never wraps.
- Latency: a flag writer issued in cycle t commits in cycle t+PIPE_DEPTH, provided there is no hold.
- Reset mid-operation: all in-flight writers are discarded and no commit occurs.

Optional Feature:
- Macro: FLAGS_FWD_EN.
- Defined:
  - issue_stall = id_valid & id_reads_flags & pending[0]. Only a writer still in EX stalls; no combinational ALU-to-ID path.
  - eff_flags = fv[k] of the youngest slot k ≥ 1 with pending[k] = 1, else flags_q.
- Undefined: base-build hazard rule; eff_flags = flags_q.

Decomposition:
- Shared package lapido_pkg:
  - FLAG_W and flag bit indices (Z, N, C, V, and the two remaining ALU flags).
  - Flag vector typedef.
  - PIPE_DEPTH default.
- One natural sub-module: flag_shadow_pipe. It holds the pending/fv shift register with hold and slot-1 kill.
- Hazard, forwarding and counter logic stay in the top module.

Test Plan:
- Writer then reader:
  - Stimulus: issue an ADD setting flags (alu_flags = 6'b000101), next cycle a reader; no FWD.
  - Response: issue_stall = 1 for 3 cycles; fl_write_enable pulses with fl_data = 6'b000101 on the third; reader issues once pending = 0; stall_count = 3.
- Same stimulus with FLAGS_FWD_EN:
  - Response: stall exactly 1 cycle; then eff_flags = 6'b000101 while flags_q is still old; stall_count = 1.
- Back-to-back writers:
  - Stimulus: 6'b000001 then 6'b000010, reader behind them, FWD on.
  - Response: eff_flags = 6'b000010 (youngest); commits occur in order on consecutive cycles.
- Flush:
  - Stimulus: writer in slot 0 plus a new writer in ID, flush = 1.
  - Response: neither reaches WB; no fl_write_enable for either; the older slot-1 writer still commits.
- pipe_hold:
  - Stimulus: 4-cycle hold with a writer in WB.
  - Response: fl_write_enable = 0 during hold; a single pulse after release; pending unchanged across hold.
- Reset:
  - Stimulus: rst mid-stream with 3 pending writers.
  - Response: next cycle pending = 0, stall_count = 0, no writes; saturation check with stall_count forced near 16'hFFFF stays at 16'hFFFF.
